// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - key event bundle from the keypad scanner to its consumer
interface keypad_scan_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (output key_code, key_valid, key_down);
    modport slave  (input  key_code, key_valid, key_down);
endinterface

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 active-low matrix keypad scanner with press/release debounce
module keypad_scan #(
    parameter int SCAN_W     = 10,
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_W      = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    keypad_scan_if.master    key
);
    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    localparam logic [SCAN_W-1:0] DWELL_LAST = '1;
    localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_CYCLES - 1);

    logic [1:0]        state;
    logic [SCAN_W-1:0] dwell;
    logic [DEB_W-1:0]  deb;
    logic [1:0]        col_idx;
    logic [1:0]        row_idx;
    logic [3:0]        rs_meta;
    logic [3:0]        rs;
    logic [1:0]        low_row;
    logic              tracked_high;

    assign col          = ~(4'b0001 << col_idx);
    assign tracked_high = rs[row_idx];

    // Lowest-index low row wins when several rows share the driven column.
    always_comb begin
        low_row = 2'd3;
        if (!rs[0])      low_row = 2'd0;
        else if (!rs[1]) low_row = 2'd1;
        else if (!rs[2]) low_row = 2'd2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= SCAN;
            dwell         <= '0;
            deb           <= '0;
            col_idx       <= 2'd0;
            row_idx       <= 2'd0;
            rs_meta       <= 4'hf;
            rs            <= 4'hf;
            key.key_code  <= 4'h0;
            key.key_valid <= 1'b0;
            key.key_down  <= 1'b0;
        end else begin
            rs_meta       <= row;
            rs            <= rs_meta;
            key.key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    dwell <= dwell + 1'b1;
                    if (dwell == DWELL_LAST) begin
                        if (rs != 4'hf) begin
                            row_idx <= low_row;
                            deb     <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 1'b1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (tracked_high) begin
                        col_idx <= col_idx + 1'b1;
                        dwell   <= '0;
                        state   <= SCAN;
                    end else if (deb == DEB_LAST) begin
                        key.key_code  <= {row_idx, col_idx};
                        key.key_valid <= 1'b1;
                        key.key_down  <= 1'b1;
                        state         <= HELD;
                    end else begin
                        deb <= deb + 1'b1;
                    end
                end
                HELD: begin
                    if (tracked_high) begin
                        deb   <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // A low sample is contact bounce; fall back without a new strobe.
                    if (!tracked_high) begin
                        state <= HELD;
                    end else if (deb == DEB_LAST) begin
                        key.key_down <= 1'b0;
                        col_idx      <= col_idx + 1'b1;
                        dwell        <= '0;
                        state        <= SCAN;
                    end else begin
                        deb <= deb + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed bench for keypad_scan with a matrix keypad model
module tb_keypad_scan;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] keys;
    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;

    keypad_scan_if bus();

    keypad_scan #(.SCAN_W(3), .DEB_CYCLES(4), .DEB_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .row   (row),
        .col   (col),
        .key   (bus)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low only while column c is driven low.
    always_comb begin
        row = 4'hf;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) if (bus.key_valid === 1'b1) pulses++;

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_col(input logic [3:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step(1);
            if (col === want) ok = 1'b1;
        end
    endtask

    task automatic wait_pulse(input int base, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step(1);
            if (pulses > base) ok = 1'b1;
        end
    endtask

    task automatic wait_up(input int max, output bit ok, output int t);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < max && !ok; i++) begin
            step(1);
            t++;
            if (bus.key_down === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        keys  = 16'h0;
        step(3);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", col); end
        checks++; if (bus.key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h expected 0", bus.key_code); end
        checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.key_valid); end
        checks++; if (bus.key_down !== 1'b0) begin errors++; $display("FAIL reset_down: got %b expected 0", bus.key_down); end
    endtask

    task automatic test_scan;
        int          at  [8] = '{4, 7, 8, 12, 20, 28, 36, 64};
        logic [3:0]  exp [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1110};
        bit          busy = 1'b0;
        int          k = 0;
        reset = 1'b0;
        for (int n = 1; n <= 64; n++) begin
            step(1);
            if (bus.key_valid !== 1'b0 || bus.key_down !== 1'b0) busy = 1'b1;
            if (k < 8 && n == at[k]) begin
                checks++;
                if (col !== exp[k]) begin errors++; $display("FAIL scan_col@%0d: got %b expected %b", n, col, exp[k]); end
                k++;
            end
        end
        checks++; if (busy) begin errors++; $display("FAIL scan_idle: got activity expected none"); end
    endtask

    task automatic test_press;
        bit ok;
        int base = pulses;
        wait_col(4'b1011, ok);
        checks++; if (!ok) begin errors++; $display("FAIL press_colwait: got timeout expected col 1011"); end
        keys = 16'h1 << 10;
        step(20);
        checks++; if (pulses - base !== 1) begin errors++; $display("FAIL press_pulses: got %0d expected 1", pulses - base); end
        checks++; if (bus.key_code !== 4'hA) begin errors++; $display("FAIL press_code: got %h expected a", bus.key_code); end
        checks++; if (bus.key_down !== 1'b1) begin errors++; $display("FAIL press_down: got %b expected 1", bus.key_down); end
        checks++; if (col !== 4'b1011) begin errors++; $display("FAIL press_col: got %b expected 1011", col); end
    endtask

    task automatic test_bounce_release;
        bit ok;
        int t;
        int base = pulses;
        keys = 16'h0;
        step(1);
        keys = 16'h1 << 10;
        step(1);
        keys = 16'h0;
        step(2);
        checks++; if (bus.key_down !== 1'b1) begin errors++; $display("FAIL rel_bounce_down: got %b expected 1", bus.key_down); end
        wait_up(30, ok, t);
        checks++; if (!ok || t < 4 || t > 6) begin errors++; $display("FAIL rel_fall: got ok=%0d after %0d cycles expected fall after 4..6", ok, t); end
        checks++; if (col !== 4'b0111) begin errors++; $display("FAIL rel_col: got %b expected 0111", col); end
        checks++; if (bus.key_code !== 4'hA) begin errors++; $display("FAIL rel_code: got %h expected a", bus.key_code); end
        checks++; if (pulses !== base) begin errors++; $display("FAIL rel_pulses: got %0d expected %0d", pulses, base); end
    endtask

    task automatic test_bounce_press;
        bit ok;
        int t;
        int base;
        wait_col(4'b1110, ok);
        wait_col(4'b0111, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_colwait: got timeout expected col 0111"); end
        step(5);
        base = pulses;
        keys = 16'h1 << 7;
        step(2);
        keys = 16'h0;
        step(1);
        keys = 16'h1 << 7;
        step(3);
        checks++; if (pulses !== base) begin errors++; $display("FAIL bp_early: got %0d pulses expected 0", pulses - base); end
        wait_pulse(base, 100, ok);
        step(3);
        checks++; if (!ok || pulses - base !== 1) begin errors++; $display("FAIL bp_pulses: got %0d expected 1", pulses - base); end
        checks++; if (bus.key_code !== 4'h7) begin errors++; $display("FAIL bp_code: got %h expected 7", bus.key_code); end
        keys = 16'h0;
        wait_up(30, ok, t);
        checks++; if (!ok) begin errors++; $display("FAIL bp_release: got key_down stuck expected 0"); end
    endtask

    task automatic test_multi_key;
        bit ok;
        int t;
        int base;
        wait_col(4'b1101, ok);
        base = pulses;
        keys = (16'h1 << 4) | (16'h1 << 12);
        wait_pulse(base, 100, ok);
        step(3);
        checks++; if (!ok || pulses - base !== 1) begin errors++; $display("FAIL mk_pulses: got %0d expected 1", pulses - base); end
        checks++; if (bus.key_code !== 4'h4) begin errors++; $display("FAIL mk_code: got %h expected 4", bus.key_code); end
        keys = 16'h1 << 12;
        wait_up(30, ok, t);
        checks++; if (!ok) begin errors++; $display("FAIL mk_release: got key_down stuck expected 0"); end
        wait_pulse(base + 1, 100, ok);
        step(2);
        checks++; if (!ok || pulses - base !== 2) begin errors++; $display("FAIL mk_redetect: got %0d pulses expected 2", pulses - base); end
        checks++; if (bus.key_code !== 4'hC) begin errors++; $display("FAIL mk_code2: got %h expected c", bus.key_code); end
        checks++; if (bus.key_down !== 1'b1) begin errors++; $display("FAIL mk_down2: got %b expected 1", bus.key_down); end
    endtask

    task automatic test_reset_held;
        bit ok;
        int base = pulses;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL rh_col: got %b expected 1110", col); end
        checks++; if (bus.key_down !== 1'b0) begin errors++; $display("FAIL rh_down: got %b expected 0", bus.key_down); end
        checks++; if (bus.key_code !== 4'h0) begin errors++; $display("FAIL rh_code: got %h expected 0", bus.key_code); end
        step(2);
        reset = 1'b0;
        wait_pulse(base, 50, ok);
        step(2);
        checks++; if (!ok || pulses - base !== 1) begin errors++; $display("FAIL rh_pulses: got %0d expected 1", pulses - base); end
        checks++; if (bus.key_code !== 4'hC) begin errors++; $display("FAIL rh_code2: got %h expected c", bus.key_code); end
        checks++; if (bus.key_down !== 1'b1) begin errors++; $display("FAIL rh_down2: got %b expected 1", bus.key_down); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press();
        test_bounce_release();
        test_bounce_press();
        test_multi_key();
        test_reset_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 active-low matrix keypad on the I/O expansion board and debounces key presses.
- Emits a 4-bit hex key code with a one-cycle valid strobe, plus a held-key level.
- It is the input-side counterpart of the time-multiplexed seven-segment driver. Its codes feed the hex digit inputs of that driver through user logic.

Parameters:
- SCAN_W, 10, width of the column dwell counter; each column is driven for 2^SCAN_W cycles (20.5 us at 50 MHz).
- DEB_CYCLES, 500000, consecutive stable samples required for press and for release (10 ms at 50 MHz).
- DEB_W, 19, width of the debounce counter; must satisfy 2^DEB_W > DEB_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- row  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clk.
- col  output  4  keypad column drive, active-low, one-hot-low.
- key_code  output  4  code of the last accepted key: row_idx*4 + col_idx.
- key_valid  output  1  one-cycle pulse when a debounced press is accepted.
- key_down  output  1  high from accepted press until debounced release.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. All registers clear asynchronously on reset.
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_down=0, state=SCAN, dwell and debounce counters=0, synchronizer=4'b1111.
- Synchronizer: row passes through a 2-FF synchronizer (rs). All decisions use rs only.
- Column drive: col_idx 0..3 drives col = 1110, 1101, 1011, 0111 respectively.
- State SCAN:
  - Dwell counter increments every cycle.
  - In the cycle where dwell = 2^SCAN_W-1 (settled sample), check rs.
  - If rs != 4'b1111: latch row_idx as the lowest-index low bit and col_idx as the current column, clear the debounce counter, go to DEBOUNCE. The column does not advance.
  - Otherwise: dwell wraps to 0 and col_idx advances, 3 wrapping to 0.
- State DEBOUNCE: column held.
  - Each cycle rs[row_idx]=0 increments the debounce counter.
  - If rs[row_idx]=1 in any cycle: go to SCAN, with the column advanced and dwell cleared.
  - When the counter reaches DEB_CYCLES: register key_code = {row_idx, col_idx}, pulse key_valid for exactly one cycle, set key_down=1, go to HELD.
- State HELD: column held. When rs[row_idx]=1, clear the debounce counter and go to RELEASE.
- State RELEASE:
  - Each cycle rs[row_idx]=1 increments the counter.
  - If rs[row_idx]=0: return to HELD (bounce). No new key_valid is generated.
  - When the counter reaches DEB_CYCLES: clear key_down, advance the column, clear dwell, go to SCAN.
- Multiple keys:
  - Only the latched key is tracked. Other rows and columns are ignored until the full release.
  - Two rows low in the same column: the lower row index wins.
- key_code holds its value after release until the next accepted press.
- key_valid never asserts twice for one physical press. Latency from rs going low: at most 4*2^SCAN_W + DEB_CYCLES + 2 cycles.
- Reset mid-operation (any state): immediate return to reset values. A key still held after reset is re-detected and re-debounced as a new press.

Test Plan (bench overrides: SCAN_W=3, DEB_CYCLES=4, DEB_W=3):
1. Reset released, row=1111 for 64 cycles → col steps 1110,1101,1011,0111,1110 every 8 cycles; key_valid=0, key_down=0.
2. Press row 2 while col=1011, held clean for 20 cycles → col frozen at 1011; key_valid pulses exactly once; key_code=4'hA (2*4+2); key_down=1.
3. Press at col=0111 row 1 with 2-cycle low / 1-cycle high bounce before stable low → no pulse during the bounce; a single pulse after 4 stable lows; key_code=4'h7.
4. Release from scenario 2 with the row toggling high/low/high before stable high → key_down stays 1 through the bounce and falls after 4 stable highs; scanning resumes at col=0111; key_code remains 4'hA.
5. Rows 1 and 3 low simultaneously at col=1110 → key_code=4'h4, a single pulse; releasing row 1 only (row 3 still low) → key_down falls, and the scan later re-detects row 3 as key_code=4'hC.
6. Assert reset during HELD → col=1110, key_down=0, key_code=0 asynchronously; key still pressed after release of reset → new debounced pulse with the same code.
